// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : muldiv_ctrl                                                |
// | Description : Sequences MULT/MULTU/DIV/DIVU between the EX stage and the  |
// |               multiplier/divider. It latches operands, pulses the unit   |
// |               enable, stalls EX until data_ok, commits HI/LO, and drains |
// |               an in-flight unit after a flush. It also performs MTHI/MTLO.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        stall,
  output logic        mul_en,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ok,
  input  logic [63:0] mul_result,
  output logic        div_en,
  output logic        div_sign,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ok,
  input  logic [63:0] div_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_op_mult  = 3'b001;
  localparam logic [2:0] c_op_multu = 3'b010;
  localparam logic [2:0] c_op_div   = 3'b011;
  localparam logic [2:0] c_op_divu  = 3'b100;
  localparam logic [2:0] c_op_mthi  = 3'b101;
  localparam logic [2:0] c_op_mtlo  = 3'b110;

  // Unit selector carried through LAUNCH/WAIT/DRAIN: 0 = multiplier, 1 = divider.
  localparam logic c_unit_mul = 1'b0;
  localparam logic c_unit_div = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_unit;
  logic        w_next_unit;
  logic        w_accept;
  logic        w_commit;

  logic        w_is_md;
  logic        w_is_mul_op;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_ok;
  logic [63:0] w_result;

  assign w_is_md     = op_valid && (op >= c_op_mult) && (op <= c_op_divu);
  assign w_is_mul_op = (op == c_op_mult) || (op == c_op_multu);
  assign w_mthi      = op_valid && !flush && (op == c_op_mthi);
  assign w_mtlo      = op_valid && !flush && (op == c_op_mtlo);

  // The controller only ever listens to the unit it launched.
  assign w_ok     = (r_unit == c_unit_div) ? div_ok : mul_ok;
  assign w_result = (r_unit == c_unit_div) ? div_result : mul_result;

  // State and unit-select register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_unit  <= c_unit_mul;
    end else begin
      r_state <= w_next_state;
      r_unit  <= w_next_unit;
    end
  end

  // Next-state, stall and launch-pulse decode; flush never leaves stall high.
  always_comb begin
    w_next_state = r_state;
    w_next_unit  = r_unit;
    stall        = 1'b0;
    mul_en       = 1'b0;
    div_en       = 1'b0;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_md && !flush) begin
          w_accept     = 1'b1;
          stall        = 1'b1;
          w_next_unit  = w_is_mul_op ? c_unit_mul : c_unit_div;
          w_next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (flush) begin
          // Enable suppressed, so nothing is in flight.
          w_next_state = S_IDLE;
        end else begin
          stall        = 1'b1;
          mul_en       = (r_unit == c_unit_mul);
          div_en       = (r_unit == c_unit_div);
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_ok) begin
          if (!flush) begin
            w_commit     = 1'b1;
            w_next_state = ex_hold ? S_DONE : S_IDLE;
          end else begin
            w_next_state = S_IDLE;
          end
        end else if (flush) begin
          w_next_state = S_DRAIN;
        end else begin
          stall = 1'b1;
        end
      end
      S_DONE: begin
        // Same EX instruction still present while held: never relaunch it.
        if (!ex_hold) begin
          w_next_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Hold off a new op until the killed one has left the unit.
        stall = w_is_md && !flush;
        if (w_ok) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Operand registers change only on an accept, so the unit sees stable inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a    <= 32'd0;
      mul_b    <= 32'd0;
      mul_sign <= 1'b0;
      div_a    <= 32'd0;
      div_b    <= 32'd0;
      div_sign <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul_op) begin
        mul_a    <= src_a;
        mul_b    <= src_b;
        mul_sign <= (op == c_op_mult);
      end else begin
        div_a    <= src_a;
        div_b    <= src_b;
        div_sign <= (op == c_op_div);
      end
    end
  end

  // Architectural HI/LO: unit commit plus MTHI/MTLO writes in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (w_commit) begin
        hi <= w_result[63:32];
        lo <= w_result[31:0];
      end
      if (w_mthi) begin
        hi <= src_a;
      end
      if (w_mtlo) begin
        lo <= src_a;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_muldiv_ctrl                                             |
// | Description : Directed self-checking bench for muldiv_ctrl with simple   |
// |               3-cycle multiplier and 6-cycle divider stubs.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ex_hold;
  logic        stall;
  logic        mul_en;
  logic        mul_sign;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ok;
  logic [63:0] mul_result;
  logic        div_en;
  logic        div_sign;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_ok;
  logic [63:0] div_result;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        stray_mul;
  logic        stray_div;
  logic [1:0]  m_cnt;
  logic [2:0]  d_cnt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  int vectors;
  int errors;

  muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .ex_hold    (ex_hold),
    .stall      (stall),
    .mul_en     (mul_en),
    .mul_sign   (mul_sign),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ok     (mul_ok),
    .mul_result (mul_result),
    .div_en     (div_en),
    .div_sign   (div_sign),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_ok     (div_ok),
    .div_result (div_result),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: en in cycle N, STAGE1 in N+1, data_ok in N+2.
  always @(posedge clk) begin
    if (rst) m_cnt <= 2'd0;
    else if (mul_en) m_cnt <= 2'd1;
    else if (m_cnt == 2'd1) m_cnt <= 2'd2;
    else m_cnt <= 2'd0;
  end

  // Divider stub: data_ok six cycles after en.
  always @(posedge clk) begin
    if (rst) d_cnt <= 3'd0;
    else if (div_en) d_cnt <= 3'd1;
    else if (d_cnt == 3'd6) d_cnt <= 3'd0;
    else if (d_cnt != 3'd0) d_cnt <= d_cnt + 3'd1;
  end

  assign mul_ok = (m_cnt == 2'd2) | stray_mul;
  assign div_ok = (d_cnt == 3'd6) | stray_div;

  // Stub datapaths read operands combinationally; a stray ok carries junk.
  always_comb begin
    if (mul_sign)
      prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    else
      prod = {32'd0, mul_a} * {32'd0, mul_b};
    if (div_b == 32'd0) begin
      quo = 32'hFFFFFFFF;
      rem = div_a;
    end else if (div_sign) begin
      quo = $signed(div_a) / $signed(div_b);
      rem = $signed(div_a) % $signed(div_b);
    end else begin
      quo = div_a / div_b;
      rem = div_a % div_b;
    end
    mul_result = stray_mul ? 64'hDEADBEEF_CAFEF00D : prod;
    div_result = stray_div ? 64'hBADC0FFE_E0DDF00D : {rem, quo};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive EX inputs at the falling edge, settle, then caller checks.
  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic f, input logic h);
    @(negedge clk);
    op_valid = v;
    op       = o;
    src_a    = a;
    src_b    = b;
    flush    = f;
    ex_hold  = h;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vectors   = 0;
    errors    = 0;
    rst       = 1'b1;
    stray_mul = 1'b0;
    stray_div = 1'b0;
    op_valid  = 1'b0;
    op        = 3'd0;
    src_a     = 32'd0;
    src_b     = 32'd0;
    flush     = 1'b0;
    ex_hold   = 1'b0;

    // Reset state
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_mul_en", {63'd0, mul_en}, 64'd0);
    chk("rst_div_en", {63'd0, div_en}, 64'd0);
    chk("rst_mul_a", {32'd0, mul_a}, 64'd0);
    rst = 1'b0;

    // MULT 0xFFFFFFFE x 3
    drive(1, 3'b001, 32'hFFFFFFFE, 32'd3, 0, 0);
    chk("mult_T_stall", {63'd0, stall}, 64'd1);
    chk("mult_T_en", {63'd0, mul_en}, 64'd0);
    drive(1, 3'b001, 32'hFFFFFFFE, 32'd3, 0, 0);
    chk("mult_T1_en", {63'd0, mul_en}, 64'd1);
    chk("mult_T1_stall", {63'd0, stall}, 64'd1);
    chk("mult_T1_sign", {63'd0, mul_sign}, 64'd1);
    drive(1, 3'b001, 32'hFFFFFFFE, 32'd3, 0, 0);
    chk("mult_T2_en", {63'd0, mul_en}, 64'd0);
    chk("mult_T2_stall", {63'd0, stall}, 64'd1);
    drive(1, 3'b001, 32'hFFFFFFFE, 32'd3, 0, 0);
    chk("mult_T3_stall", {63'd0, stall}, 64'd0);
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

    // MULTU same operands, src_a disturbed after accept
    drive(1, 3'b010, 32'hFFFFFFFE, 32'd3, 0, 0);
    chk("multu_T_stall", {63'd0, stall}, 64'd1);
    drive(1, 3'b010, 32'h11111111, 32'd3, 0, 0);
    chk("multu_T1_en", {63'd0, mul_en}, 64'd1);
    chk("multu_T1_sign", {63'd0, mul_sign}, 64'd0);
    drive(1, 3'b010, 32'h22222222, 32'd3, 0, 0);
    drive(1, 3'b010, 32'h33333333, 32'd3, 0, 0);
    chk("multu_T3_stall", {63'd0, stall}, 64'd0);
    chk("multu_T3_mul_a", {32'd0, mul_a}, 64'h00000000_FFFFFFFE);
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("multu_hilo", {hi, lo}, 64'h00000002_FFFFFFFA);

    // DIV -7 / 2 with 6-cycle divider
    drive(1, 3'b011, 32'hFFFFFFF9, 32'd2, 0, 0);
    chk("div_T_stall", {63'd0, stall}, 64'd1);
    drive(1, 3'b011, 32'hFFFFFFF9, 32'd2, 0, 0);
    chk("div_T1_en", {62'd0, div_en, mul_en}, 64'd2);
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'b011, 32'hFFFFFFF9, 32'd2, 0, 0);
      chk("div_wait_stall", {63'd0, stall}, 64'd1);
    end
    drive(1, 3'b011, 32'hFFFFFFF9, 32'd2, 0, 0);
    chk("div_ok_stall", {63'd0, stall}, 64'd0);
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // MULT 5x7 flushed in WAIT, then MULT 6x7 queued behind the drain
    drive(1, 3'b001, 32'd5, 32'd7, 0, 0);
    drive(1, 3'b001, 32'd5, 32'd7, 0, 0);
    chk("flush_T1_en", {63'd0, mul_en}, 64'd1);
    drive(1, 3'b001, 32'd5, 32'd7, 1, 0);
    chk("flush_T2_stall", {63'd0, stall}, 64'd0);
    drive(1, 3'b001, 32'd6, 32'd7, 0, 0);
    chk("drain_T3_stall", {63'd0, stall}, 64'd1);
    chk("drain_T3_en", {63'd0, mul_en}, 64'd0);
    drive(1, 3'b001, 32'd6, 32'd7, 0, 0);
    chk("drain_T4_stall", {63'd0, stall}, 64'd1);
    chk("drain_T4_en", {63'd0, mul_en}, 64'd0);
    chk("drain_hilo_kept", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    drive(1, 3'b001, 32'd6, 32'd7, 0, 0);
    chk("relaunch_T5_en", {63'd0, mul_en}, 64'd1);
    chk("relaunch_T5_mul_a", {32'd0, mul_a}, 64'd6);
    drive(1, 3'b001, 32'd6, 32'd7, 0, 0);
    chk("relaunch_T6_stall", {63'd0, stall}, 64'd1);
    drive(1, 3'b001, 32'd6, 32'd7, 0, 0);
    chk("relaunch_T7_stall", {63'd0, stall}, 64'd0);
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("relaunch_hilo", {hi, lo}, 64'h00000000_0000002A);

    // MULT 3x4 with ex_hold across the commit, stray oks while parked
    drive(1, 3'b001, 32'd3, 32'd4, 0, 0);
    drive(1, 3'b001, 32'd3, 32'd4, 0, 0);
    chk("hold_T1_en", {63'd0, mul_en}, 64'd1);
    drive(1, 3'b001, 32'd3, 32'd4, 0, 0);
    drive(1, 3'b001, 32'd3, 32'd4, 0, 1);
    chk("hold_T3_stall", {63'd0, stall}, 64'd0);
    drive(1, 3'b001, 32'd3, 32'd4, 0, 1);
    chk("hold_T4_en", {63'd0, mul_en}, 64'd0);
    chk("hold_T4_stall", {63'd0, stall}, 64'd0);
    chk("hold_T4_hilo", {hi, lo}, 64'h00000000_0000000C);
    drive(1, 3'b001, 32'd3, 32'd4, 0, 1);
    stray_mul = 1'b1;
    #1;
    chk("hold_T5_en", {63'd0, mul_en}, 64'd0);
    chk("hold_T5_stall", {63'd0, stall}, 64'd0);
    drive(1, 3'b001, 32'd3, 32'd4, 0, 0);
    stray_mul = 1'b0;
    #1;
    chk("hold_T6_hilo", {hi, lo}, 64'h00000000_0000000C);
    chk("hold_T6_en", {63'd0, mul_en}, 64'd0);
    drive(0, 3'd0, 0, 0, 0, 0);
    stray_div = 1'b1;
    #1;
    chk("idle_stray_en", {62'd0, div_en, mul_en}, 64'd0);
    drive(0, 3'd0, 0, 0, 0, 0);
    stray_div = 1'b0;
    #1;
    chk("idle_stray_hilo", {hi, lo}, 64'h00000000_0000000C);

    // MTHI / MTLO, with and without flush
    drive(1, 3'b101, 32'h12345678, 32'd0, 0, 0);
    chk("mthi_stall", {63'd0, stall}, 64'd0);
    drive(1, 3'b110, 32'h0BADF00D, 32'd0, 0, 0);
    chk("mthi_hi", {32'd0, hi}, 64'h00000000_12345678);
    chk("mtlo_stall", {63'd0, stall}, 64'd0);
    drive(1, 3'b101, 32'hAAAA5555, 32'd0, 1, 0);
    chk("mtlo_lo", {32'd0, lo}, 64'h00000000_0BADF00D);
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("mthi_flush_hi", {32'd0, hi}, 64'h00000000_12345678);

    // Reserved op and flushed MULT in IDLE are not accepted
    drive(1, 3'b111, 32'd9, 32'd9, 0, 0);
    chk("rsvd_stall", {63'd0, stall}, 64'd0);
    drive(1, 3'b100, 32'd9, 32'd9, 1, 0);
    chk("rsvd_next_en", {62'd0, div_en, mul_en}, 64'd0);
    chk("idle_flush_stall", {63'd0, stall}, 64'd0);
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("idle_flush_next_en", {62'd0, div_en, mul_en}, 64'd0);

    // Reset while WAIT
    drive(1, 3'b001, 32'd2, 32'd2, 0, 0);
    drive(1, 3'b001, 32'd2, 32'd2, 0, 0);
    drive(1, 3'b001, 32'd2, 32'd2, 0, 0);
    chk("rstw_T2_stall", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("rstw_hilo", {hi, lo}, 64'd0);
    chk("rstw_mul_a", {32'd0, mul_a}, 64'd0);
    rst = 1'b0;
    drive(0, 3'd0, 0, 0, 0, 0);
    chk("rstw_idle_stall", {63'd0, stall}, 64'd0);
    chk("rstw_idle_en", {62'd0, div_en, mul_en}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller between the EX stage and the HI/LO arithmetic units. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, latches operands, and launches the 3-cycle multiplier or the variable-latency divider with an `en` pulse. It stalls the pipeline until the unit returns `data_ok`, then commits the result to the architectural HI/LO registers. It also handles flush mid-operation, draining any in-flight unit before it accepts a new launch.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  EX holds a valid instruction.
- `op`  in  3  encoding:
  - 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU
  - 101 MTHI, 110 MTLO, 111 reserved (treated as none)
- `src_a`, `src_b`  in  32 each  rs and rt operand values.
- `flush`  in  1  kill the EX instruction this cycle (exception or eret).
- `ex_hold`  in  1  EX is held by another stall source this cycle.
- `stall`  out  1  HI/LO stall request to the pipeline (combinational).
- `mul_en`  out  1  one-cycle launch pulse to the multiplier.
- `mul_sign`  out  1  1 for MULT.
- `mul_a`, `mul_b`  out  32 each  latched multiplier operands.
- `mul_ok`  in  1  multiplier `data_ok`.
- `mul_result`  in  64  signed or unsigned product; HI = [63:32], LO = [31:0].
- `div_en`, `div_sign`, `div_a`, `div_b`  out  same as the multiplier set, driven to the divider.
- `div_ok`  in  1  divider `data_ok`.
- `div_result`  in  64  {remainder, quotient}; HI = remainder, LO = quotient.
- `hi`, `lo`  out  32 each  architectural HI/LO, registered.

## Operation
- `is_md` = `op_valid` & op in {001..100].
- States:
  - IDLE
  - LAUNCH (unit bit: mul or div)
  - WAIT (unit bit)
  - DONE
  - DRAIN (unit bit)
- Transitions from IDLE:
  - `is_md` & !`flush`: latch `src_a`, `src_b` and the sign into the unit's operand registers, then go to LAUNCH.
  - Otherwise stay in IDLE.
- Transitions from LAUNCH:
  - Assert the unit's `en` for this cycle only.
  - `flush` suppresses `en` and returns to IDLE; nothing is in flight.
  - Otherwise go to WAIT.
- Transitions from WAIT:
  - On the unit's `ok` with !`flush`: write HI/LO, then go to DONE if `ex_hold`, else IDLE.
  - `ok` & `flush`: discard the result and go to IDLE.
  - `flush` without `ok`: go to DRAIN.
- DONE: stay while `ex_hold`, go to IDLE when it drops. No relaunch, since the same EX instruction is still present.
- DRAIN: go to IDLE on the unit's `ok`. The result is discarded and HI/LO are never written.
- Stall rules:
  - `stall` = 1 in the IDLE accept cycle, in LAUNCH, and in WAIT while the unit's `ok` is 0.
  - `stall` = 0 in WAIT on the `ok` cycle, and 0 in DONE.
  - In DRAIN, `stall` = `is_md` & !`flush`; the new op is accepted on the IDLE cycle after the drain.
  - `flush` forces `stall` = 0 in every state.
- Operand hold: the unit samples its operands combinationally through its `data_ok` cycle. `mul_a`/`mul_b`/`mul_sign` (and the div set) therefore change only on a new accept into LAUNCH for that unit.
- MTHI/MTLO:
  - `op_valid` & !`flush` writes `src_a` to `hi` (MTHI) or `lo` (MTLO) at the clock edge. Allowed in any state.
  - `stall` = 0.
  - A write during `ex_hold` is idempotent.
- A stray `mul_ok` or `div_ok` in IDLE or DONE is ignored.
- No special case for a zero divisor; the controller commits whatever `div_result` returns.
- Reset values: state IDLE; `hi`, `lo`, all operand registers, `mul_en`, `div_en` = 0; `stall` = 0. Reset mid-operation abandons the op without a drain, because the units share `rst`.

## Timing
- MULT accepted in cycle T:
  - LAUNCH with `mul_en` = 1 in T+1.
  - Multiplier STAGE1 in T+2, `mul_ok` in T+3.
  - `stall` = 1 in T..T+2 and 0 in T+3.
  - HI/LO are written at the end of T+3 and visible in T+4.
- DIV: `div_en` in T+1; `stall` holds until the `div_ok` cycle, then follows the same commit rule.
- Back-to-back MULTs: the second is accepted at the earliest in T+4, the first IDLE cycle, when the multiplier is idle again.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 at T -> `mul_en` only in T+1; `stall` high T..T+2; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA in T+4.
- MULTU same operands -> HI = 0x00000002, LO = 0xFFFFFFFA. Change `src_a` during T+1..T+3 -> result unchanged.
- DIV -7/2 with a divider stub returning `div_ok` 6 cycles after `div_en` -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFD; `stall` low only on the `ok` cycle.
- MULT with `flush` in T+2 -> DRAIN; HI/LO unchanged.
  - A new MULT presented in T+3 -> `stall` = 1.
  - Accepted in T+4 after `mul_ok`; `mul_en` in T+5; its result is committed.
- MULT with `ex_hold` = 1 during T+3..T+5 -> DONE; no second `mul_en`; HI/LO written once.
- MTHI 0x12345678 -> `hi` = 0x12345678 next cycle, `stall` never asserted. Same op with `flush` -> `hi` unchanged. `rst` during WAIT -> `hi` = `lo` = 0, IDLE.
